// File: rtl/alu_bist_pkg.sv
// Shared constants and types for the ALU built-in self-test sequencer:
// opcode table, LFSR/MISR polynomials, operand scrambling mask and FSM states.
package alu_bist_pkg;

   localparam int NUM_OPS = 10;

   // Entry i is the opcode issued when op_idx == i (entry 0 is the rightmost).
   localparam logic [NUM_OPS-1:0][3:0] OP_TABLE = {
      4'b1001, 4'b1000, 4'b0111, 4'b0110, 4'b0101,
      4'b0100, 4'b0011, 4'b0010, 4'b0001, 4'b0000
   };

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] SRCB_XOR  = 32'h5A5A_5A5A;

   localparam logic [3:0] OP_SLL = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;

   function automatic logic isShiftOp(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/alu_bist_misr.sv
// Multiple-input signature register: shifts left with polynomial feedback and
// folds in one data word per enabled cycle. Clear has priority over enable.
module alu_bist_misr
   import alu_bist_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] POLY  = MISR_POLY
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] sig_o,
   output logic [WIDTH-1:0] sigNext_o
);

   logic [WIDTH-1:0] sig_q;

   assign sigNext_o = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_i;
   assign sig_o     = sig_q;

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         sig_q <= '0;
      end else if (enable_i) begin
         sig_q <= sigNext_o;
      end
   end

endmodule

// File: rtl/alu_bist.sv
// BIST sequencer: drives pseudo-random operand pairs through all ten ALU
// operations and compacts ALUResult into a MISR. Optional golden comparison
// is built only when ALU_BIST_COMPARE_EN is defined; otherwise pass is 0.
module alu_bist
   import alu_bist_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    OPCODE_LENGTH = 4,
   parameter int                    NUM_VECTORS   = 256,
   parameter logic [DATA_WIDTH-1:0] SEED          = 32'hACE1_2345,
   parameter logic [DATA_WIDTH-1:0] GOLDEN_SIG    = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [DATA_WIDTH-1:0]    signature,
   output logic [DATA_WIDTH-1:0]    SrcA,
   output logic [DATA_WIDTH-1:0]    SrcB,
   output logic [OPCODE_LENGTH-1:0] Operation,
   input  logic [DATA_WIDTH-1:0]    ALUResult
);

   localparam int CNT_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
   localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS - 1);

   state_t                   state_q, state_d;
   logic [DATA_WIDTH-1:0]    lfsr_q, lfsr_d;
   logic [3:0]               opIdx_q, opIdx_d;
   logic [CNT_W-1:0]         vecCnt_q, vecCnt_d;
   logic [DATA_WIDTH-1:0]    srcA_q, srcA_d, srcB_q, srcB_d, sig_q, sig_d;
   logic [OPCODE_LENGTH-1:0] op_q, op_d;
   logic                     busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic                     present, misrClear, misrEnable, matchGolden;
   logic [3:0]               nextOp;
   logic [DATA_WIDTH-1:0]    misrNext, unusedMisrSig;

   alu_bist_misr #(.WIDTH(DATA_WIDTH), .POLY(MISR_POLY)) misrInst (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (misrClear),
      .enable_i  (misrEnable),
      .data_i    (ALUResult),
      .sig_o     (unusedMisrSig),
      .sigNext_o (misrNext)
   );

`ifdef ALU_BIST_COMPARE_EN
   assign matchGolden = (misrNext == GOLDEN_SIG);
`else
   logic unusedGolden;
   assign unusedGolden = ^GOLDEN_SIG;
   assign matchGolden  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         lfsr_q   <= '0;
         opIdx_q  <= '0;
         vecCnt_q <= '0;
         srcA_q   <= '0;
         srcB_q   <= '0;
         op_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         sig_q    <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         opIdx_q  <= opIdx_d;
         vecCnt_q <= vecCnt_d;
         srcA_q   <= srcA_d;
         srcB_q   <= srcB_d;
         op_q     <= op_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         sig_q    <= sig_d;
      end
   end

   // The registered ALU-side outputs are built from the *next* LFSR/op index,
   // so the vector seen in a cycle is the one whose result the MISR absorbs.
   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      opIdx_d    = opIdx_q;
      vecCnt_d   = vecCnt_q;
      done_d     = done_q;
      pass_d     = pass_q;
      sig_d      = sig_q;
      present    = 1'b0;
      misrClear  = 1'b0;
      misrEnable = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = RUN;
               lfsr_d    = SEED;
               opIdx_d   = '0;
               vecCnt_d  = '0;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               misrClear = 1'b1;
               present   = 1'b1;
            end
         end
         RUN: begin
            misrEnable = 1'b1;
            if (opIdx_q == 4'(NUM_OPS - 1)) begin
               opIdx_d  = '0;
               lfsr_d   = {lfsr_q[DATA_WIDTH-2:0], 1'b0} ^ (lfsr_q[DATA_WIDTH-1] ? LFSR_POLY : '0);
               vecCnt_d = vecCnt_q + 1'b1;
               if (vecCnt_q == LAST_VEC) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  sig_d   = misrNext;
                  pass_d  = matchGolden;
               end else begin
                  present = 1'b1;
               end
            end else begin
               opIdx_d = opIdx_q + 4'd1;
               present = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      nextOp = OP_TABLE[opIdx_d];
      busy_d = present;
      srcA_d = present ? lfsr_d : '0;
      srcB_d = '0;
      op_d   = '0;
      if (present) begin
         srcB_d = {lfsr_d[15:0], lfsr_d[31:16]} ^ SRCB_XOR;
         if (isShiftOp(nextOp)) begin
            srcB_d[DATA_WIDTH-1:5] = '0;
         end
         op_d = OPCODE_LENGTH'(nextOp);
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig_q;
   assign SrcA      = srcA_q;
   assign SrcB      = srcB_q;
   assign Operation = op_q;

endmodule
